// File: rtl/cpu_dbg_pkg.sv
// Shared types for the CPU debug snapshot block: FSM state encoding,
// register widths and the captured register bundle.
package cpu_dbg_pkg;

    localparam int PC_W  = 16;
    localparam int REG_W = 8;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_FROZEN = 2'd1,
        ST_HALT   = 2'd2
    } state_t;

    typedef struct packed {
        logic [PC_W-1:0]  pc;
        logic [REG_W-1:0] sp;
        logic [REG_W-1:0] ir;
        logic [REG_W-1:0] p;
    } dbg_regs_t;

endpackage

// File: rtl/key_debounce.sv
// Push-button conditioner: 2-FF synchroniser, stability counter and a
// one-cycle pulse on an accepted press (high-to-low); releases are silent.
module key_debounce #(
    parameter int DEBOUNCE_CYC = 1000000
) (
    input  logic i_clk,
    input  logic i_rstn,
    input  logic i_key_n,
    output logic o_press
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);

    logic             key_p0;
    logic             key_p1;
    logic             stable;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            key_p0  <= 1'b1;
            key_p1  <= 1'b1;
            stable  <= 1'b1;
            cnt     <= '0;
            o_press <= 1'b0;
        end else begin
            key_p0  <= i_key_n;
            key_p1  <= key_p0;
            o_press <= 1'b0;
            // any sample matching the accepted level restarts the stability window
            if (key_p1 == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(DEBOUNCE_CYC - 1)) begin
                stable  <= key_p1;
                cnt     <= '0;
                o_press <= ~key_p1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/cpu_dbg_snapshot.sv
// Samples CPU debug state at instruction boundaries and a slow refresh rate,
// with KEY-driven freeze and a single-PC breakpoint that halts the CPU.
module cpu_dbg_snapshot
    import cpu_dbg_pkg::*;
#(
    parameter int REFRESH_CYC  = 5000000,
    parameter int DEBOUNCE_CYC = 1000000
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic [PC_W-1:0]  i_nes_cpu_pc,
    input  logic [REG_W-1:0] i_nes_cpu_sp,
    input  logic [REG_W-1:0] i_nes_cpu_ir,
    input  logic [REG_W-1:0] i_nes_cpu_p,
    input  logic             i_cpu_sync,
    input  logic             i_key_n,
    input  logic             i_bp_en,
    input  logic [PC_W-1:0]  i_bp_addr,
    output logic [PC_W-1:0]  o_disp_pc,
    output logic [REG_W-1:0] o_disp_sp,
    output logic [REG_W-1:0] o_disp_ir,
    output logic [REG_W-1:0] o_disp_p,
    output logic             o_frozen,
    output logic             o_bp_hit,
    output logic             o_cpu_halt
);

    if (REFRESH_CYC < 2) begin : g_bad_refresh
        $error("cpu_dbg_snapshot: REFRESH_CYC must be >= 2");
    end

    localparam int RCNT_W = $clog2(REFRESH_CYC);

    state_t            state;
    logic [RCNT_W-1:0] refresh_cnt;
    logic              armed;
    logic              bp_mask;
    logic              press;
    logic              tick;
    logic              pc_eq;
    logic              bp_match;
    logic              capture;
    dbg_regs_t         snap;

    key_debounce #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_key (
        .i_clk   (i_clk),
        .i_rstn  (i_rstn),
        .i_key_n (i_key_n),
        .o_press (press)
    );

    assign tick     = (refresh_cnt == RCNT_W'(REFRESH_CYC - 1));
    assign pc_eq    = (i_nes_cpu_pc == i_bp_addr);
    assign bp_match = (state == ST_RUN) && i_bp_en && i_cpu_sync && pc_eq && !bp_mask;
    // a breakpoint hit always captures so the display shows the halting instruction
    assign capture  = (state == ST_RUN) && i_cpu_sync && (armed || tick || bp_match);

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state       <= ST_RUN;
            refresh_cnt <= '0;
            armed       <= 1'b1;
            bp_mask     <= 1'b0;
            o_frozen    <= 1'b0;
            o_bp_hit    <= 1'b0;
            o_cpu_halt  <= 1'b0;
        end else begin
            refresh_cnt <= tick ? '0 : refresh_cnt + 1'b1;

            if (capture) begin
                armed <= 1'b0;
            end else if (tick) begin
                armed <= 1'b1;
            end

            if (i_cpu_sync && !pc_eq) begin
                bp_mask <= 1'b0;
            end

            // a breakpoint hit outranks a simultaneous press, which is dropped
            case (state)
                ST_RUN: begin
                    if (bp_match) begin
                        state      <= ST_HALT;
                        o_bp_hit   <= 1'b1;
                        o_cpu_halt <= 1'b1;
                    end else if (press) begin
                        state    <= ST_FROZEN;
                        o_frozen <= 1'b1;
                    end
                end
                ST_FROZEN: begin
                    if (press) begin
                        state    <= ST_RUN;
                        o_frozen <= 1'b0;
                        armed    <= 1'b1;
                    end
                end
                ST_HALT: begin
                    // resume masked so the same fetch cannot immediately re-halt
                    if (press) begin
                        state      <= ST_RUN;
                        o_bp_hit   <= 1'b0;
                        o_cpu_halt <= 1'b0;
                        bp_mask    <= 1'b1;
                    end
                end
                default: begin
                    state      <= ST_RUN;
                    o_frozen   <= 1'b0;
                    o_bp_hit   <= 1'b0;
                    o_cpu_halt <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            snap <= '0;
        end else if (capture) begin
            snap <= '{pc: i_nes_cpu_pc, sp: i_nes_cpu_sp, ir: i_nes_cpu_ir, p: i_nes_cpu_p};
        end
    end

    assign o_disp_pc = snap.pc;
    assign o_disp_sp = snap.sp;
    assign o_disp_ir = snap.ir;
    assign o_disp_p  = snap.p;

    a_halt_is_hit : assert property (@(posedge i_clk) o_cpu_halt == o_bp_hit);
    a_not_both    : assert property (@(posedge i_clk) !(o_frozen && o_cpu_halt));

endmodule

// File: tb/tb_cpu_dbg_snapshot.sv
// Bench for cpu_dbg_snapshot: directed scenarios plus random traffic,
// checked every cycle against a behavioural model.
module tb_cpu_dbg_snapshot;

    localparam int R = 8;
    localparam int D = 4;

    logic        clk = 1'b0;
    logic        rstn;
    logic [15:0] pc;
    logic [7:0]  sp, ir, p;
    logic        sync;
    logic        key_n;
    logic        bp_en;
    logic [15:0] bp_addr;
    logic [15:0] o_disp_pc;
    logic [7:0]  o_disp_sp, o_disp_ir, o_disp_p;
    logic        o_frozen, o_bp_hit, o_cpu_halt;

    always #5 clk = ~clk;

    cpu_dbg_snapshot #(.REFRESH_CYC(R), .DEBOUNCE_CYC(D)) dut (
        .i_clk        (clk),
        .i_rstn       (rstn),
        .i_nes_cpu_pc (pc),
        .i_nes_cpu_sp (sp),
        .i_nes_cpu_ir (ir),
        .i_nes_cpu_p  (p),
        .i_cpu_sync   (sync),
        .i_key_n      (key_n),
        .i_bp_en      (bp_en),
        .i_bp_addr    (bp_addr),
        .o_disp_pc    (o_disp_pc),
        .o_disp_sp    (o_disp_sp),
        .o_disp_ir    (o_disp_ir),
        .o_disp_p     (o_disp_p),
        .o_frozen     (o_frozen),
        .o_bp_hit     (o_bp_hit),
        .o_cpu_halt   (o_cpu_halt)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: mode 0=running, 1=frozen, 2=halted
    int          m_mode;
    bit          m_armed, m_mask, m_pend, m_acc, m_valid = 1'b0;
    int          m_n;
    logic [15:0] m_pc;
    logic [7:0]  m_sp, m_ir, m_p;
    bit          hist[$];

    always @(posedge clk) begin : model
        bit press, tick, match, cap, run_ok;
        if (!rstn) begin
            m_mode = 0; m_armed = 1; m_mask = 0; m_pend = 0; m_acc = 1; m_n = 0;
            m_pc = 0; m_sp = 0; m_ir = 0; m_p = 0;
            hist.delete();
            repeat (D + 3) hist.push_back(1'b1);
            m_valid = 1'b1;
        end else begin
            press = m_pend;
            tick  = ((m_n % R) == R - 1);
            m_n++;
            match = (m_mode == 0) && bp_en && sync && (pc == bp_addr) && !m_mask;
            cap   = (m_mode == 0) && sync && (m_armed || tick || match);
            if (cap) begin m_pc = pc; m_sp = sp; m_ir = ir; m_p = p; end
            if (cap) m_armed = 0; else if (tick) m_armed = 1;
            if (sync && pc != bp_addr) m_mask = 0;
            if (m_mode == 0) begin
                if (match) m_mode = 2; else if (press) m_mode = 1;
            end else if (m_mode == 1) begin
                if (press) begin m_mode = 0; m_armed = 1; end
            end else begin
                if (press) begin m_mode = 0; m_mask = 1; end
            end
            // key seen by the debouncer now is the pin value from two edges ago;
            // the level is accepted after D consecutive differing samples
            hist.push_back(key_n);
            void'(hist.pop_front());
            run_ok = 1;
            for (int i = 0; i < D; i++)
                if (hist[hist.size() - 3 - i] == m_acc) run_ok = 0;
            m_pend = 0;
            if (run_ok) begin
                m_acc  = !m_acc;
                m_pend = !m_acc;
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("disp_pc", 32'(o_disp_pc), 32'(m_pc));
            check("disp_sp", 32'(o_disp_sp), 32'(m_sp));
            check("disp_ir", 32'(o_disp_ir), 32'(m_ir));
            check("disp_p", 32'(o_disp_p), 32'(m_p));
            check("frozen", 32'(o_frozen), 32'(m_mode == 1));
            check("bp_hit", 32'(o_bp_hit), 32'(m_mode == 2));
            check("cpu_halt", 32'(o_cpu_halt), 32'(m_mode == 2));
        end
    end

    task automatic cyc4(input bit s, input logic [15:0] a, input bit k,
                        input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
        @(negedge clk);
        sync = s; pc = a; key_n = k; sp = b; ir = c; p = d;
    endtask

    task automatic cyc(input bit s, input logic [15:0] a, input bit k);
        cyc4(s, a, k, 8'($urandom), 8'($urandom), 8'($urandom));
    endtask

    task automatic settle;
        @(posedge clk);
        #1;
    endtask

    task automatic press_key;
        repeat (6) cyc(1'b0, 16'h0, 1'b0);
        repeat (8) cyc(1'b0, 16'h0, 1'b1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_pc"}, 32'(o_disp_pc), 32'h0);
        check({tag, "_sp"}, 32'(o_disp_sp), 32'h0);
        check({tag, "_ir"}, 32'(o_disp_ir), 32'h0);
        check({tag, "_p"}, 32'(o_disp_p), 32'h0);
        check({tag, "_frozen"}, 32'(o_frozen), 32'h0);
        check({tag, "_bp_hit"}, 32'(o_bp_hit), 32'h0);
        check({tag, "_halt"}, 32'(o_cpu_halt), 32'h0);
    endtask

    initial begin
        bit kv;
        int hold;
        rstn = 1'b0; key_n = 1'b1; sync = 1'b0; bp_en = 1'b0; bp_addr = 16'h0;
        pc = 16'h0; sp = 8'h0; ir = 8'h0; p = 8'h0;
        repeat (2) @(negedge clk);
        settle();
        check_all_zero("reset");

        // periodic capture, then tick coincident with sync
        @(negedge clk); rstn = 1'b1; sync = 1'b0;
        cyc(1'b0, 16'h0, 1'b1);
        cyc4(1'b1, 16'hC000, 1'b1, 8'hFD, 8'h78, 8'h24);
        settle();
        check("cap_pc", 32'(o_disp_pc), 32'hC000);
        check("cap_sp", 32'(o_disp_sp), 32'hFD);
        check("cap_ir", 32'(o_disp_ir), 32'h78);
        check("cap_p", 32'(o_disp_p), 32'h24);
        for (int i = 1; i <= 4; i++) cyc(1'b1, 16'(16'hC000 + i), 1'b1);
        settle();
        check("unarmed_hold", 32'(o_disp_pc), 32'hC000);
        cyc(1'b1, 16'h8123, 1'b1);
        settle();
        check("tick_cap", 32'(o_disp_pc), 32'h8123);
        cyc(1'b1, 16'hC0FF, 1'b1);
        settle();
        check("disarmed_after_tick", 32'(o_disp_pc), 32'h8123);

        // glitch rejection
        repeat (2) cyc(1'b0, 16'h0, 1'b0);
        repeat (8) cyc(1'b0, 16'h0, 1'b1);
        settle();
        check("glitch_frozen", 32'(o_frozen), 32'h0);

        // freeze across several ticks, then thaw
        press_key();
        settle();
        check("freeze_on", 32'(o_frozen), 32'h1);
        repeat (3 * R) cyc(1'b1, 16'($urandom), 1'b1);
        settle();
        check("freeze_hold", 32'(o_disp_pc), 32'h8123);
        press_key();
        settle();
        check("freeze_off", 32'(o_frozen), 32'h0);
        cyc(1'b1, 16'h1234, 1'b1);
        settle();
        check("thaw_cap", 32'(o_disp_pc), 32'h1234);

        // breakpoint, resume mask, re-hit
        bp_en = 1'b1; bp_addr = 16'hE1F0;
        cyc(1'b1, 16'h0002, 1'b1);
        cyc(1'b1, 16'hE1F0, 1'b1);
        settle();
        check("bp_pc", 32'(o_disp_pc), 32'hE1F0);
        check("bp_halt", 32'(o_cpu_halt), 32'h1);
        check("bp_hit", 32'(o_bp_hit), 32'h1);
        repeat (3) cyc(1'b1, 16'h4444, 1'b1);
        settle();
        check("halt_ignores_sync", 32'(o_disp_pc), 32'hE1F0);
        press_key();
        settle();
        check("resume_halt", 32'(o_cpu_halt), 32'h0);
        cyc(1'b1, 16'hE1F0, 1'b1);
        settle();
        check("masked_refetch", 32'(o_cpu_halt), 32'h0);
        cyc(1'b1, 16'hE1F3, 1'b1);
        cyc(1'b1, 16'hE1F0, 1'b1);
        settle();
        check("rehit_halt", 32'(o_cpu_halt), 32'h1);

        // breakpoint and press on the same cycle, then reset mid-halt
        press_key();
        settle();
        check("resume2", 32'(o_cpu_halt), 32'h0);
        cyc(1'b1, 16'hE1F3, 1'b1);
        repeat (6) cyc(1'b0, 16'h0, 1'b0);
        cyc(1'b1, 16'hE1F0, 1'b0);
        settle();
        check("prio_halt", 32'(o_cpu_halt), 32'h1);
        check("prio_frozen", 32'(o_frozen), 32'h0);
        cyc(1'b0, 16'h0, 1'b0);
        @(negedge clk); rstn = 1'b0;
        settle();
        check_all_zero("midhalt_rst");
        @(negedge clk); rstn = 1'b1; key_n = 1'b1; sync = 1'b0;

        // random traffic
        kv = 1'b1; hold = 0;
        for (int i = 0; i < 3000; i++) begin
            if (hold == 0) begin
                kv = ~kv;
                hold = (kv == 1'b0) ? $urandom_range(1, 10) : $urandom_range(1, 12);
            end
            hold--;
            cyc(($urandom_range(0, 2) == 0),
                ($urandom_range(0, 2) == 0) ? bp_addr : 16'(bp_addr + $urandom_range(1, 3)), kv);
            if ($urandom_range(0, 199) == 0) bp_en = ~bp_en;
            rstn = ($urandom_range(0, 499) != 0);
        end
        @(negedge clk); rstn = 1'b1;
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
